// File: rtl/decoded_word_buffer_if.sv
// rtl/decoded_word_buffer_if.sv - word ingress strobe and head-of-FIFO handshake bundle
interface decoded_word_buffer_if #(
    parameter int DATA_W = 16
) ();
    logic [DATA_W-1:0] in_word;
    logic              in_valid;
    logic [DATA_W-1:0] out_word;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_word,
        output in_valid,
        output out_ready,
        input  out_word,
        input  out_valid
    );

    modport slave (
        input  in_word,
        input  in_valid,
        input  out_ready,
        output out_word,
        output out_valid
    );
endinterface

// File: rtl/decoded_word_buffer.sv
// rtl/decoded_word_buffer.sv - FWFT buffer for decoded words with checksum, count and overflow
module decoded_word_buffer #(
    parameter int              DEPTH    = 4,
    parameter int              DATA_W   = 16,
    parameter logic [DATA_W-1:0] CHK_INIT = '0
) (
    input  logic                       clk,
    input  logic                       pon_rst_n_i,
    decoded_word_buffer_if.slave       bus,
    input  logic                       clear,
    output logic [$clog2(DEPTH):0]     fill_level,
    output logic                       overflow,
    output logic [DATA_W-1:0]          checksum,
    output logic [7:0]                 word_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              out_valid;
    logic              pop;
    logic              push;
    logic              accept;

    assign out_valid     = (fill_level != '0);
    assign pop           = out_valid & bus.out_ready;
    assign push          = bus.in_valid & ((fill_level < FULL_LVL) | pop);
    assign accept        = push & ~clear;

    assign bus.out_valid = out_valid;
    // Head is masked while empty so the unreset memory never leaks out.
    assign bus.out_word  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= bus.in_word;
        end
    end

    always_ff @(posedge clk or negedge pon_rst_n_i) begin
        if (!pon_rst_n_i) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fill_level <= '0;
            overflow   <= 1'b0;
            checksum   <= CHK_INIT;
            word_count <= '0;
        end else if (clear) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fill_level <= '0;
            overflow   <= 1'b0;
            checksum   <= CHK_INIT;
            word_count <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + PTR_W'(1);
                checksum <= {checksum[DATA_W-2:0], checksum[DATA_W-1]} ^ bus.in_word;
                if (word_count != 8'hFF) begin
                    word_count <= word_count + 8'd1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                fill_level <= fill_level + CNT_W'(1);
            end else if (pop && !push) begin
                fill_level <= fill_level - CNT_W'(1);
            end
            if (bus.in_valid && !push) begin
                overflow <= 1'b1;
            end
        end
    end
endmodule
